// File: rtl/led_strip_driver.sv
// led_strip_driver: register bank, pixel RAM and WS2812-style one-wire NRZ serializer.
// Define LED_PIXEL_READBACK_EN to make PIXEL words readable over the local bus.
module led_strip_driver #(
   parameter int G_ADDR_WIDTH = 14,
   parameter int G_MAX_LEDS   = 256,
   parameter int G_T0H        = 40,
   parameter int G_T1H        = 80,
   parameter int G_TBIT       = 125,
   parameter int G_TRESET     = 5000
) (
   input  logic                    axi_clk,
   input  logic                    axi_rst_n,
   input  logic [G_ADDR_WIDTH-1:0] local_addr,
   input  logic [31:0]             local_wr_data,
   input  logic                    local_wr,
   output logic [31:0]             local_rd_data,
   output logic                    led_dout,
   output logic                    led_busy,
   output logic                    frame_done
);
   localparam int AW = G_ADDR_WIDTH - 2;
   localparam int IW = G_MAX_LEDS > 1 ? $clog2(G_MAX_LEDS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, BIT, LATCH} state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [4:0]    bit_q, bit_d;
   logic [23:0]   shift_q, shift_d;
   logic [11:0]   idx_q, idx_d, num_q, num_d, nleds_q, nleds_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          last_q, last_d, busy_q, busy_d, done_q, done_d;
   logic          fdone_q, fdone_d, dout_q, dout_d, wr_q;
   logic [31:0]   rd_q, rd_d;
   logic [23:0]   ram [G_MAX_LEDS];
   logic [23:0]   ram_q;
   logic [AW-1:0] waddr, pix_off;
   logic [IW-1:0] bus_idx;
   logic          pix_hit, eval, start, fetch, unused_addr;

   assign waddr       = local_addr[G_ADDR_WIDTH-1:2];
   assign pix_off     = waddr - AW'(1024);
   assign pix_hit     = waddr >= AW'(1024) && 32'(pix_off) < G_MAX_LEDS;
   assign bus_idx     = pix_off[IW-1:0];
   assign unused_addr = ^local_addr[1:0];
   // START is acted on once, in the first cycle after a write burst ends
   assign eval        = wr_q && !local_wr;
   assign start       = eval && ctrl_q[0] && state_q == IDLE;

   assign rd_d = waddr == AW'(0) ? {30'd0, ctrl_q[1], 1'b0}
               : waddr == AW'(1) ? {30'd0, done_q, busy_q}
               : waddr == AW'(2) ? {20'd0, nleds_q} : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      num_d   = num_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = done_q;
      fdone_d = 1'b0;
      fetch   = 1'b0;
      ctrl_d  = (local_wr && waddr == AW'(0)) ? local_wr_data[1:0] : ctrl_q;
      if (eval) ctrl_d[0] = 1'b0;
      nleds_d = !(local_wr && waddr == AW'(2)) ? nleds_q
              : local_wr_data > 32'(G_MAX_LEDS) ? 12'(G_MAX_LEDS) : local_wr_data[11:0];
      case (state_q)
         IDLE: if (start) begin
            num_d   = nleds_q;
            done_d  = nleds_q == '0;
            fdone_d = nleds_q == '0;
            busy_d  = nleds_q != '0;
            state_d = nleds_q == '0 ? IDLE : LOAD;
         end
         LOAD: begin
            fetch   = 1'b1;
            state_d = BIT;
         end
         BIT: if (cnt_q != 16'(G_TBIT - 1)) cnt_d = cnt_q + 16'd1;
         else if (bit_q != 5'd23) begin
            cnt_d   = '0;
            bit_d   = bit_q + 5'd1;
            shift_d = shift_q << 1;
         end else if (last_q) begin
            cnt_d   = '0;
            state_d = LATCH;
         end else fetch = 1'b1;
         LATCH: if (cnt_q != 16'(G_TRESET - 1)) cnt_d = cnt_q + 16'd1;
         else begin
            fdone_d = 1'b1;
            num_d   = nleds_q;
            if (ctrl_q[1] && nleds_q != '0) state_d = LOAD;
            else begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // ram_q already holds the prefetched next pixel; the index wraps to 0 after the last one
      if (fetch) begin
         shift_d = ram_q;
         cnt_d   = '0;
         bit_d   = '0;
         last_d  = idx_q == num_q - 12'd1;
         idx_d   = last_d ? '0 : idx_q + 12'd1;
      end
      dout_d = state_d == BIT && cnt_d < (shift_d[23] ? 16'(G_T1H) : 16'(G_T0H));
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n)
      if (!axi_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         idx_q   <= '0;
         num_q   <= '0;
         nleds_q <= '0;
         ctrl_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fdone_q <= 1'b0;
         dout_q  <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         nleds_q <= nleds_d;
         ctrl_q  <= ctrl_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fdone_q <= fdone_d;
         dout_q  <= dout_d;
         wr_q    <= local_wr;
         rd_q    <= rd_d;
      end

   always_ff @(posedge axi_clk) begin
      if (local_wr && pix_hit) ram[bus_idx] <= local_wr_data[23:0];
      ram_q <= ram[idx_q[IW-1:0]];
   end

`ifdef LED_PIXEL_READBACK_EN
   logic [23:0] ram_rd_q;
   logic        pix_sel_q;

   always_ff @(posedge axi_clk) ram_rd_q <= ram[bus_idx];

   always_ff @(posedge axi_clk or negedge axi_rst_n)
      if (!axi_rst_n) pix_sel_q <= 1'b0;
      else pix_sel_q <= pix_hit;

   assign local_rd_data = pix_sel_q ? {8'd0, ram_rd_q} : rd_q;
`else
   assign local_rd_data = rd_q;
`endif

   assign led_dout   = dout_q;
   assign led_busy   = busy_q;
   assign frame_done = fdone_q;
endmodule

// File: tb/tb_led_strip_driver.sv
// tb_led_strip_driver: random pixel frames checked against a waveform model built from pulse rules.
module tb_led_strip_driver;
   localparam int TBIT = 125, T0H = 40, T1H = 80, TRESET = 5000, MAXL = 256;
   localparam logic [13:0] A_CTRL = 14'h0000, A_STAT = 14'h0004, A_NUM = 14'h0008;
`ifdef LED_PIXEL_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic        axi_clk = 1'b0, axi_rst_n = 1'b0;
   logic [13:0] local_addr = '0;
   logic [31:0] local_wr_data = '0;
   logic        local_wr = 1'b0;
   logic [31:0] local_rd_data;
   logic        led_dout, led_busy, frame_done;

   int          n_cmp = 0, n_bad = 0;
   logic [23:0] pix_m [MAXL];
   int          frames[$];
   logic        cap_d[$], cap_b[$], cap_f[$];
   logic        exp_d[$], exp_b[$], exp_f[$];

   led_strip_driver dut (
      .axi_clk       (axi_clk),
      .axi_rst_n     (axi_rst_n),
      .local_addr    (local_addr),
      .local_wr_data (local_wr_data),
      .local_wr      (local_wr),
      .local_rd_data (local_rd_data),
      .led_dout      (led_dout),
      .led_busy      (led_busy),
      .frame_done    (frame_done)
   );

   always #5 axi_clk = ~axi_clk;

   function automatic logic [13:0] pix_a(input int i);
      return 14'h1000 + 14'(4 * i);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [13:0] a, input logic [31:0] d, input int len = 1);
      @(negedge axi_clk);
      local_addr    = a;
      local_wr_data = d;
      local_wr      = 1'b1;
      repeat (len) @(negedge axi_clk);
      local_wr = 1'b0;
      if (a >= 14'h1000 && int'((a - 14'h1000) >> 2) < MAXL) pix_m[int'((a - 14'h1000) >> 2)] = d[23:0];
   endtask

   task automatic rdchk(input string tag, input logic [13:0] a, input logic [31:0] exp);
      @(negedge axi_clk);
      local_addr = a;
      @(negedge axi_clk);
      chk(tag, local_rd_data, exp);
   endtask

   // Expected samples from the cycle after START evaluation: per frame one load cycle,
   // 24 bit slots per pixel (high T1H or T0H of TBIT), TRESET low; frame_done right after.
   function automatic void build_exp(input int tail);
      int fd_at[$];
      int busy_len;
      exp_d.delete();
      exp_b.delete();
      exp_f.delete();
      foreach (frames[f]) begin
         exp_d.push_back(1'b0);
         for (int p = 0; p < frames[f]; p++)
            for (int b = 23; b >= 0; b--)
               for (int c = 0; c < TBIT; c++) exp_d.push_back(c < (pix_m[p][b] ? T1H : T0H));
         repeat (TRESET) exp_d.push_back(1'b0);
         fd_at.push_back(exp_d.size());
      end
      busy_len = exp_d.size();
      repeat (tail) exp_d.push_back(1'b0);
      for (int i = 0; i < exp_d.size(); i++) begin
         exp_b.push_back(i < busy_len);
         exp_f.push_back(1'b0);
      end
      foreach (fd_at[j]) exp_f[fd_at[j]] = 1'b1;
   endfunction

   task automatic capture(input int len);
      cap_d.delete();
      cap_b.delete();
      cap_f.delete();
      for (int i = 0; i < len; i++) begin
         @(negedge axi_clk);
         cap_d.push_back(led_dout);
         cap_b.push_back(led_busy);
         cap_f.push_back(frame_done);
      end
   endtask

   task automatic compare_run(input string tag);
      int md = 0, mb = 0, mf = 0, first = -1;
      for (int i = 0; i < exp_d.size(); i++) begin
         if (cap_d[i] !== exp_d[i]) begin
            md++;
            if (first < 0) first = i;
         end
         if (cap_b[i] !== exp_b[i]) mb++;
         if (cap_f[i] !== exp_f[i]) mf++;
      end
      chk({tag, "_dout_first_bad_idx"}, first, -1);
      chk({tag, "_dout_bad_cycles"}, md, 0);
      chk({tag, "_busy_bad_cycles"}, mb, 0);
      chk({tag, "_frame_done_bad_cycles"}, mf, 0);
   endtask

   function automatic logic [23:0] decode(input int base);
      logic [23:0] v;
      for (int b = 0; b < 24; b++) begin
         int h = 0;
         for (int c = 0; c < TBIT; c++) if (cap_d[base + b * TBIT + c] === 1'b1) h++;
         v[23 - b] = h > (T0H + T1H) / 2;
      end
      return v;
   endfunction

   function automatic int hi_len(input int i);
      int n = 0;
      while (i + n < cap_d.size() && cap_d[i + n] === 1'b1) n++;
      return n;
   endfunction

   initial begin
      logic [31:0] v;
      repeat (3) @(negedge axi_clk);
      axi_rst_n = 1'b1;
      @(negedge axi_clk);
      chk("rst_dout", led_dout, 0);
      chk("rst_busy", led_busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_rd_data", local_rd_data, 0);
      rdchk("rst_status", A_STAT, 0);
      rdchk("rst_num", A_NUM, 0);
      rdchk("rst_ctrl", A_CTRL, 0);

      // single pixel, reference pattern
      wr(A_NUM, 1);
      wr(pix_a(0), 32'h0080_0001);
      rdchk("tp_num", A_NUM, 1);
      frames = {1};
      build_exp(20);
      wr(A_CTRL, 1);
      capture(exp_d.size());
      compare_run("tp");
      chk("tp_pixel", decode(1), 24'h800001);
      chk("tp_first_high", hi_len(1), T1H);
      chk("tp_bit2_high", hi_len(1 + TBIT), T0H);
      chk("tp_bit24_high", hi_len(1 + 23 * TBIT), T1H);
      rdchk("tp_status", A_STAT, 2);
      rdchk("tp_ctrl", A_CTRL, 0);

      // START held for a 4-cycle strobe, then a START while busy
      v = $urandom();
      wr(pix_a(0), v);
      frames = {1};
      build_exp(20);
      wr(A_CTRL, 1, 4);
      fork
         capture(exp_d.size());
         begin
            repeat (500) @(negedge axi_clk);
            wr(A_CTRL, 1);
            rdchk("hold_status_busy", A_STAT, 1);
         end
      join
      compare_run("hold");
      chk("hold_pixel", decode(1), pix_m[0]);
      rdchk("hold_status", A_STAT, 2);

      // looping frames: NUM_LEDS changed mid-frame, LOOP cleared in the second frame
      for (int p = 0; p < 3; p++) wr(pix_a(p), $urandom());
      wr(A_NUM, 3);
      frames = {3, 1};
      build_exp(20);
      wr(A_CTRL, 3);
      fork
         capture(exp_d.size());
         begin
            repeat (1000) @(negedge axi_clk);
            wr(A_NUM, 1);
            repeat (14500) @(negedge axi_clk);
            wr(A_CTRL, 0);
         end
      join
      compare_run("loop");
      for (int p = 0; p < 3; p++) chk($sformatf("loop_f0_pixel%0d", p), decode(1 + p * 24 * TBIT), pix_m[p]);
      chk("loop_f1_pixel0", decode(14001 + 1), pix_m[0]);
      rdchk("loop_status", A_STAT, 2);
      rdchk("loop_num", A_NUM, 1);

      // random two-pixel one-shot frame
      for (int p = 0; p < 2; p++) wr(pix_a(p), $urandom());
      wr(A_NUM, 2);
      frames = {2};
      build_exp(20);
      wr(A_CTRL, 1);
      capture(exp_d.size());
      compare_run("rnd");
      for (int p = 0; p < 2; p++) chk($sformatf("rnd_pixel%0d", p), decode(1 + p * 24 * TBIT), pix_m[p]);

      // zero-length frame and NUM_LEDS clamping
      wr(A_NUM, 0);
      frames.delete();
      build_exp(10);
      exp_f[0] = 1'b1;
      wr(A_CTRL, 1);
      capture(exp_d.size());
      compare_run("zero");
      rdchk("zero_status", A_STAT, 2);
      wr(A_NUM, 4000);
      rdchk("clamp_4000", A_NUM, 256);
      wr(A_NUM, 256);
      rdchk("clamp_256", A_NUM, 256);

      // pixel readback and unmapped space
      wr(pix_a(5), 32'hA512_3456);
      rdchk("rb_pix5", pix_a(5), RB ? 32'h0012_3456 : 32'h0);
      wr(14'h1400, 32'h00FF_FFFF);
      rdchk("unmapped_1400", 14'h1400, 0);
      rdchk("unmapped_000c", 14'h000C, 0);
      rdchk("rb_pix0_no_alias", pix_a(0), RB ? {8'd0, pix_m[0]} : 32'h0);

      // asynchronous reset in the middle of a high pulse
      wr(A_NUM, 1);
      wr(pix_a(0), 32'h0080_0001);
      wr(A_CTRL, 1);
      repeat (12) @(negedge axi_clk);
      chk("mid_dout_high", led_dout, 1);
      axi_rst_n = 1'b0;
      #1;
      chk("mid_rst_dout", led_dout, 0);
      chk("mid_rst_busy", led_busy, 0);
      repeat (2) @(negedge axi_clk);
      axi_rst_n = 1'b1;
      rdchk("mid_status", A_STAT, 0);
      rdchk("mid_ctrl", A_CTRL, 0);
      rdchk("mid_num", A_NUM, 0);
      rdchk("mid_pix5_kept", pix_a(5), RB ? 32'h0012_3456 : 32'h0);
      repeat (5) @(negedge axi_clk);
      chk("mid_idle_dout", led_dout, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/led_strip_driver.md
# led_strip_driver

Register bank and WS2812-style serial LED driver that sits directly behind the AXI4-Lite slave's local bus. It receives `local_addr`, `local_wr_data` and `local_wr`, and returns `local_rd_data`. Software loads a pixel RAM and control registers, and the block streams GRB pixels as one-wire NRZ pulses on `led_dout`, followed by a latch/reset gap, either once or looping.

## Interface
- `G_ADDR_WIDTH`, 14, local byte-address width.
- `G_MAX_LEDS`, 256, pixel RAM depth; must be ≤ 3072.
- `G_T0H`, 40, high time of a 0 bit, in clocks.
- `G_T1H`, 80, high time of a 1 bit, in clocks.
- `G_TBIT`, 125, bit period in clocks; must be > `G_T1H`.
- `G_TRESET`, 5000, low latch time after a frame, in clocks; must be < 65536.

Ports:
- `axi_clk`  in  1  sole clock.
- `axi_rst_n`  in  1  asynchronous, active-low reset.
- `local_addr`  in  G_ADDR_WIDTH  byte address; bits [1:0] are ignored.
- `local_wr_data`  in  32  write data.
- `local_wr`  in  1  write strobe; may stay high for several cycles.
- `local_rd_data`  out  32  registered read data.
- `led_dout`  out  1  serial LED data.
- `led_busy`  out  1  high while a frame or latch gap is in progress.
- `frame_done`  out  1  one-cycle pulse at the end of each latch gap.

## Operation
Register map:
- `0x0000` CTRL (R/W)
  - bit0 START: command bit, reads back as 0.
  - bit1 LOOP.
- `0x0004` STATUS (RO)
  - bit0 BUSY.
  - bit1 DONE: sticky; set at the end of a non-loop frame, cleared by an accepted START.
- `0x0008` NUM_LEDS (R/W): 12 bits, value 0..G_MAX_LEDS; larger values are clamped to G_MAX_LEDS.
- `0x1000 + 4*i` PIXEL[i] (R/W): bits [23:16] G, [15:8] R, [7:0] B. Bits [31:24] read as 0. Sent MSB (G7) first.
- Unmapped addresses: writes are ignored, reads return 0.

Write and read behaviour:
- Every cycle with `local_wr=1` writes the addressed register or RAM word; the last write wins.
- START side effects are evaluated once, in the cycle after `local_wr` falls, using the final latched CTRL bit0.
- START while BUSY is ignored.
- START with NUM_LEDS=0 sets DONE and pulses `frame_done` without driving `led_dout`.

State machine (IDLE, LOAD, BIT, LATCH):
- IDLE → LOAD on an accepted START. NUM_LEDS is captured at this point; later writes take effect at the next frame start.
- LOAD → BIT after a 1-cycle RAM read of pixel 0 into a 24-bit shift register.
- BIT: each bit lasts exactly G_TBIT clocks.
  - `led_dout` is high for G_T0H or G_T1H clocks, then low.
  - The next pixel is prefetched during the current pixel, so there is no gap between pixels.
  - After bit 23 of the last pixel → LATCH.
- LATCH: `led_dout` is low for G_TRESET clocks, then `frame_done` pulses.
  - If LOOP=1 → LOAD (pixel 0, NUM_LEDS re-captured).
  - Otherwise → IDLE with DONE=1.
- Clearing LOOP mid-frame: the current frame and its latch complete, then the block goes to IDLE.
- Pixel RAM writes while BUSY are allowed; tearing is accepted. The RAM is dual-port: bus R/W on one port, driver read on the other.

## Timing
- Reset values: `local_rd_data`=0, `led_dout`=0, `led_busy`=0, `frame_done`=0, CTRL=0, NUM_LEDS=0, DONE=0. Pixel RAM is not cleared.
- Reset asserted mid-frame: `led_dout` goes low immediately (asynchronous) and the state is IDLE.
- Read latency: `local_rd_data` is valid 1 clock after `local_addr` is presented and is held until the address changes.
- First `led_dout` rise occurs 2 clocks after the START evaluation cycle.
- Frame length: NUM_LEDS·24·G_TBIT + G_TRESET clocks.
- `led_busy` rises 1 clock after START evaluation and falls in the same cycle as `frame_done`.
- Counters: the bit counter is 16 bits and the pixel index is 12 bits. Pixel index wrap at NUM_LEDS-1 ends the frame.

## Configuration
- `LED_PIXEL_READBACK_EN` defined: PIXEL reads return RAM contents with the 1-clock latency above.
- Not defined: PIXEL reads return 0, and the bus port is write-only, so the RAM maps to a simple dual-port RAM. Register reads are unaffected.

## Test plan
- Reset release: STATUS reads 0, `led_dout`=0, NUM_LEDS reads 0.
- NUM_LEDS=1, PIXEL[0]=0x00800001, START:
  - First bit high for 80 clocks; bits 2–23 high for 40 clocks, except bit 24 of the stream (B0), which is high for 80.
  - Then 5000 low clocks, one `frame_done` pulse, STATUS=0x2.
- NUM_LEDS=3 with LOOP=1: pixel boundaries show exactly 125-clock periods with no gap. A second frame starts right after the latch. Clearing LOOP mid-frame ends after that frame's latch.
- START held high across a 4-cycle `local_wr` strobe: exactly one frame starts. A second START while BUSY is ignored.
- NUM_LEDS=0, START: DONE set and `frame_done` pulse with no `led_dout` activity. Writing NUM_LEDS=4000 reads back 256.
- Assert `axi_rst_n` low mid-bit while `led_dout`=1: output drops immediately and STATUS=0 after release. Run with and without `LED_PIXEL_READBACK_EN`; a PIXEL[5] readback returns the written value or 0 respectively.
